// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter using shift-and-add-3, one input bit per clock.
// Start/busy/done handshake; result and overflow flag are held until the next conversion completes.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4,
    parameter bit SAT    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int PW    = ((BIN_W > BCD_W) ? BIN_W : BCD_W) + 1;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [PW-1:0] pow10(input int n);
        logic [PW-1:0] p;
        p = {{(PW-1){1'b0}}, 1'b1};
        for (int i = 0; i < n; i++) begin
            p = p * PW'(10);
        end
        return p;
    endfunction

    // Any digit >= 5 gets +3 so that the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = s[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = s[4*d +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [PW-1:0]    POW10     = pow10(DIGITS);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [BIN_W-1:0]   shreg_r, shreg_nxt_s;
    logic [BCD_W-1:0]   scr_r, scr_nxt_s, scr_adj_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               ovf_pend_r, ovf_pend_nxt_s;
    logic [BCD_W-1:0]   bcd_r, bcd_nxt_s;
    logic               ovf_r, ovf_nxt_s;
    logic               busy_r, done_r;
    logic               ovf_in_s;

    // Range check of the incoming value, done at full width so no bits are lost.
    assign ovf_in_s  = ({{(PW-BIN_W){1'b0}}, bin_in} >= POW10);
    assign scr_adj_s = add3(scr_r);

    // Next-state, datapath and result-write logic.
    always_comb begin
        state_nxt_s    = state_r;
        shreg_nxt_s    = shreg_r;
        scr_nxt_s      = scr_r;
        cnt_nxt_s      = cnt_r;
        ovf_pend_nxt_s = ovf_pend_r;
        bcd_nxt_s      = bcd_r;
        ovf_nxt_s      = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    shreg_nxt_s    = bin_in;
                    scr_nxt_s      = {BCD_W{1'b0}};
                    ovf_pend_nxt_s = ovf_in_s;
                    cnt_nxt_s      = CNT_W'(BIN_W);
                    state_nxt_s    = SHIFT;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            SHIFT: begin
                // The bit leaving the top digit is dropped, which yields the modulo-10^DIGITS result.
                scr_nxt_s   = {scr_adj_s[BCD_W-2:0], shreg_r[BIN_W-1]};
                shreg_nxt_s = shreg_r << 1'b1;
                cnt_nxt_s   = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    bcd_nxt_s   = (SAT && ovf_pend_r) ? ALL_NINES : scr_nxt_s;
                    ovf_nxt_s   = ovf_pend_r;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; RST overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            shreg_r    <= {BIN_W{1'b0}};
            scr_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ovf_pend_r <= 1'b0;
            bcd_r      <= {BCD_W{1'b0}};
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shreg_r    <= shreg_nxt_s;
            scr_r      <= scr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ovf_pend_r <= ovf_pend_nxt_s;
            bcd_r      <= bcd_nxt_s;
            ovf_r      <= ovf_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_nxt_s == DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd_out  = bcd_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq: saturating and wrapping 16-bit/4-digit
// instances share stimulus; an 8-bit/3-digit instance is swept back-to-back.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_ab;
    logic [15:0] bin_ab;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] bcd_b;
    logic        start_c;
    logic [7:0]  bin_c;
    logic        busy_c, done_c, ovf_c;
    logic [11:0] bcd_c;

    int n_chk = 0;
    int n_err = 0;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SAT(1'b1)) dut_a (
        .CLK(clk), .RST(rst), .start(start_ab), .bin_in(bin_ab),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a));

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SAT(1'b0)) dut_b (
        .CLK(clk), .RST(rst), .start(start_ab), .bin_in(bin_ab),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b));

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SAT(1'b1)) dut_c (
        .CLK(clk), .RST(rst), .start(start_c), .bin_in(bin_c),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c));

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal arithmetic on the integer value, then pack digits.
    function automatic longint ref_bcd(input longint v, input int digits, input bit sat,
                                       output bit ovf);
        longint p;
        longint w;
        longint r;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        ovf = (v >= p);
        w = (ovf && sat) ? (p - 1) : (v % p);
        r = 0;
        for (int i = 0; i < digits; i++) begin
            r = r | ((w % 10) << (4 * i));
            w = w / 10;
        end
        return r;
    endfunction

    task automatic conv_ab(input logic [15:0] v);
        int     lat;
        int     bcyc;
        longint ea;
        longint eb;
        bit     oa;
        bit     ob;
        bin_ab   = v;
        start_ab = 1'b1;
        @(posedge clk); #1;
        start_ab = 1'b0;
        lat  = -1;
        bcyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy_a) bcyc++;
            if (done_a && lat < 0) lat = k;
            if (k > 0 && !busy_a) break;
            @(posedge clk); #1;
        end
        ea = ref_bcd(longint'(v), 4, 1'b1, oa);
        eb = ref_bcd(longint'(v), 4, 1'b0, ob);
        chk_eq("latency", longint'(lat), 64'd16);
        chk_eq("busy_cycles", longint'(bcyc), 64'd17);
        chk_eq("bcd_sat", longint'(bcd_a), ea);
        chk_eq("ovf_sat", longint'(ovf_a), longint'(oa));
        chk_eq("bcd_wrap", longint'(bcd_b), eb);
        chk_eq("ovf_wrap", longint'(ovf_b), longint'(ob));
    endtask

    initial begin
        int     ndone;
        int     n;
        longint e;
        bit     o;
        logic [15:0] v;

        rst = 1'b1; start_ab = 1'b0; bin_ab = 16'd0; start_c = 1'b0; bin_c = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", longint'(busy_a), 64'd0);
        chk_eq("rst_done", longint'(done_a), 64'd0);
        chk_eq("rst_bcd", longint'(bcd_a), 64'd0);
        chk_eq("rst_ovf", longint'(ovf_a), 64'd0);
        chk_eq("rst_busy_c", longint'(busy_c), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        conv_ab(16'd140);
        chk_eq("val_140", longint'(bcd_a), 64'h0140);
        conv_ab(16'd9999);
        conv_ab(16'd10000);
        chk_eq("val_10000_sat", longint'(bcd_a), 64'h9999);
        conv_ab(16'd65535);
        chk_eq("val_65535_wrap", longint'(bcd_b), 64'h5535);
        conv_ab(16'd0);
        conv_ab(16'd1);

        // A second start during a conversion must be ignored.
        bin_ab = 16'd123; start_ab = 1'b1;
        @(posedge clk); #1;
        start_ab = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done_a) ndone++;
            if (k == 4) begin
                start_ab = 1'b1; bin_ab = 16'd77;
            end else if (k == 5) begin
                start_ab = 1'b0;
            end
        end
        chk_eq("ignore_done_count", longint'(ndone), 64'd1);
        chk_eq("ignore_bcd", longint'(bcd_a), 64'h0123);
        chk_eq("ignore_ovf", longint'(ovf_a), 64'd0);

        // Reset in the middle of a conversion aborts it.
        bin_ab = 16'd500; start_ab = 1'b1;
        @(posedge clk); #1;
        start_ab = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_eq("abort_busy", longint'(busy_a), 64'd0);
        chk_eq("abort_done", longint'(done_a), 64'd0);
        chk_eq("abort_bcd", longint'(bcd_a), 64'd0);
        chk_eq("abort_ovf", longint'(ovf_a), 64'd0);
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done_a) ndone++;
        end
        chk_eq("abort_no_done", longint'(ndone), 64'd0);
        conv_ab(16'd42);
        chk_eq("after_abort_42", longint'(bcd_a), 64'h0042);

        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) v = 16'($urandom_range(9990, 10010));
            else            v = 16'($urandom_range(0, 65535));
            conv_ab(v);
        end

        // 8-bit, 3-digit: full sweep with start held high.
        bin_c = 8'd0; start_c = 1'b1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!done_c && n < 40);
            chk_eq("sweep_spacing", longint'(n), (i == 0) ? 64'd9 : 64'd10);
            e = ref_bcd(longint'(i), 3, 1'b1, o);
            chk_eq("sweep_bcd", longint'(bcd_c), e);
            chk_eq("sweep_ovf", longint'(ovf_c), longint'(o));
            bin_c = 8'(i + 1);
        end
        start_c = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
